// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the block instruction memory; optional trailing XOR checksum under INSTR_LOADER_CHECKSUM_EN.
// Write strobe one cycle after the 4th data byte; in_ready drops only while a commit/halt waits for sample_tick.
module instr_mem_loader #(
  parameter int n_blocks = 256,
  localparam int AW = $clog2(n_blocks)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_tick,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] instr_write_addr,
  output logic [31:0]   instr_write_val,
  output logic          instr_write_enable,
  output logic [AW-1:0] n_blocks_running,
  output logic [AW-1:0] last_block,
  output logic          pipeline_enable,
  output logic          busy,
  output logic          error
);

  localparam logic [AW-1:0] TOP_BLOCK = AW'(n_blocks - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_ADDR  = 3'd1,
    W_COUNT = 3'd2,
    W_DATA  = 3'd3,
    C_ARG   = 3'd4,
    C_WAIT  = 3'd5
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    W_CSUM  = 3'd6
`endif
  } state_t;

  state_t        state, next_state;
  logic          accept;
  logic          last_byte;
  logic [1:0]    byte_cnt;
  logic [7:0]    word_cnt;
  logic [AW-1:0] addr;
  logic [23:0]   word_sr;
  logic [AW-1:0] pend_lb;
  logic [AW-1:0] pend_nbr;
  logic          pend_halt;
  logic [AW-1:0] arg_lb;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (state == W_DATA) && (byte_cnt == 2'd3);
  assign busy      = (state != IDLE);
  assign arg_lb    = in_byte[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (in_byte)
            8'h01:   next_state = W_ADDR;
            8'h02:   next_state = C_ARG;
            8'h03:   next_state = C_WAIT;
            default: next_state = IDLE;
          endcase
        end
      end
      W_ADDR:  if (accept) next_state = W_COUNT;
      W_COUNT: if (accept) next_state = W_DATA;
      W_DATA: begin
        if (last_byte && word_cnt == 8'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          next_state = W_CSUM;
`else
          next_state = IDLE;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      W_CSUM:  if (accept) next_state = IDLE;
`endif
      C_ARG:   if (accept) next_state = C_WAIT;
      C_WAIT:  if (sample_tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready           <= 1'b0;
      instr_write_addr   <= '0;
      instr_write_val    <= '0;
      instr_write_enable <= 1'b0;
      n_blocks_running   <= '0;
      last_block         <= '0;
      pipeline_enable    <= 1'b1;
      error              <= 1'b0;
      byte_cnt           <= '0;
      word_cnt           <= '0;
      addr               <= '0;
      word_sr            <= '0;
      pend_lb            <= '0;
      pend_nbr           <= '0;
      pend_halt          <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum               <= '0;
`endif
    end else begin
      in_ready           <= (next_state != C_WAIT);
      instr_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (in_byte)
              8'h01: begin
                pipeline_enable <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum            <= in_byte;
`endif
              end
              8'h02: ;
              8'h03: begin
                pend_halt <= 1'b1;
                pend_nbr  <= '0;
              end
              default: error <= 1'b1;
            endcase
          end
        end
        W_ADDR: begin
          if (accept) begin
            addr <= arg_lb;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum <= csum ^ in_byte;
`endif
          end
        end
        W_COUNT: begin
          if (accept) begin
            word_cnt <= in_byte;
            byte_cnt <= 2'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_byte;
`endif
          end
        end
        W_DATA: begin
          if (accept) begin
            // Bytes arrive LSB first, so shift right and drop the newest byte in at the top.
            word_sr  <= {in_byte, word_sr[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_byte;
`endif
          end
          if (last_byte) begin
            instr_write_val    <= {in_byte, word_sr};
            instr_write_addr   <= addr;
            instr_write_enable <= 1'b1;
            addr               <= addr + AW'(1);
            word_cnt           <= word_cnt - 8'd1;
`ifndef INSTR_LOADER_CHECKSUM_EN
            if (word_cnt == 8'd0) pipeline_enable <= 1'b1;
`endif
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        W_CSUM: begin
          if (accept) begin
            // A corrupt program is halted at once rather than waiting for a sample tick.
            if (in_byte != csum) begin
              error            <= 1'b1;
              n_blocks_running <= '0;
            end
            pipeline_enable <= 1'b1;
          end
        end
`endif
        C_ARG: begin
          if (accept) begin
            pend_halt <= 1'b0;
            pend_lb   <= arg_lb;
            pend_nbr  <= (arg_lb == TOP_BLOCK) ? TOP_BLOCK : arg_lb + AW'(1);
          end
        end
        C_WAIT: begin
          if (sample_tick) begin
            n_blocks_running <= pend_nbr;
            if (!pend_halt) last_block <= pend_lb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: expected writes go to a scoreboard queue, a monitor pops on each strobe.
module tb_instr_mem_loader;

  localparam int NB = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  instr_write_addr;
  logic [31:0] instr_write_val;
  logic        instr_write_enable;
  logic [7:0]  n_blocks_running;
  logic [7:0]  last_block;
  logic        pipeline_enable;
  logic        busy;
  logic        error;

  instr_mem_loader #(.n_blocks(NB)) dut (
    .clk                (clk),
    .reset              (reset),
    .sample_tick        (sample_tick),
    .in_byte            (in_byte),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .instr_write_addr   (instr_write_addr),
    .instr_write_val    (instr_write_val),
    .instr_write_enable (instr_write_enable),
    .n_blocks_running   (n_blocks_running),
    .last_block         (last_block),
    .pipeline_enable    (pipeline_enable),
    .busy               (busy),
    .error              (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] val;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] wq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          exp_strobes = 0;
  int          last_strobe = -100;
  logic [7:0]  m_nbr = 8'd0;
  logic [7:0]  m_lb = 8'd0;
  logic        m_err = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!reset && instr_write_enable) begin
      strobes++;
      check("strobe_spacing_ok", (cyc - last_strobe) >= 4, 1);
      last_strobe = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: addr 0x%0h val 0x%0h, none expected", instr_write_addr, instr_write_val);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", instr_write_addr, mon_e.addr);
        check("wr_val", instr_write_val, mon_e.val);
      end
    end
  end

  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready) begin
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: in_ready stayed %0b, expected 1 within 200 cycles", in_ready);
        break;
      end
      tick_cycle();
      n++;
    end
    tick_cycle();
    in_valid = 1'b0;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick_cycle();
  endtask

  task automatic check_state(string tag);
    check({tag, "_nbr"}, n_blocks_running, m_nbr);
    check({tag, "_last_block"}, last_block, m_lb);
    check({tag, "_error"}, error, m_err);
    check({tag, "_pipe_en"}, pipeline_enable, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 0);
    check("rst_we", instr_write_enable, 0);
    check("rst_addr", instr_write_addr, 0);
    check("rst_val", instr_write_val, 0);
    check("rst_nbr", n_blocks_running, 0);
    check("rst_last_block", last_block, 0);
    check("rst_pipe_en", pipeline_enable, 1);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
  endtask

  // Words come from wq when preloaded, otherwise random.
  task automatic do_write(input logic [7:0] addr, input int cnt, input bit corrupt);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    cs = 8'h01;
    send_byte(8'h01, 0);
    check("pipe_en_low_in_frame", pipeline_enable, 0);
    check("busy_in_frame", busy, 1);
    send_byte(addr, 1);
    cs ^= addr;
    send_byte(8'(cnt), 1);
    cs ^= 8'(cnt);
    for (int wi = 0; wi <= cnt; wi++) begin
      if (wq.size() > 0) w = wq.pop_front();
      else               w = $urandom();
      exp_q.push_back('{addr: 8'((int'(addr) + wi) % NB), val: w});
      exp_strobes++;
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        cs ^= b;
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(b, 2);
`else
        send_byte(b, (wi == cnt && k == 3) ? 0 : 2);
`endif
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(corrupt ? ~cs : cs, 0);
    if (corrupt) begin
      m_err = 1'b1;
      m_nbr = 8'd0;
    end
`else
    if (corrupt) $display("note: checksum build disabled, corruption request ignored");
`endif
    check_state("after_write");
  endtask

  task automatic wait_tick(input int delay);
    check("cwait_in_ready", in_ready, 0);
    check("cwait_busy", busy, 1);
    for (int d = 0; d < delay; d++) begin
      tick_cycle();
      check("cwait_hold_in_ready", in_ready, 0);
      check("cwait_hold_nbr", n_blocks_running, m_nbr);
    end
    sample_tick = 1'b1;
    tick_cycle();
    sample_tick = 1'b0;
  endtask

  task automatic do_commit(input logic [7:0] lb, input int delay);
    send_byte(8'h02, 0);
    send_byte(lb, 0);
    wait_tick(delay);
    m_lb  = lb;
    m_nbr = (int'(lb) + 1 > NB - 1) ? 8'(NB - 1) : 8'(int'(lb) + 1);
    check_state("after_commit");
  endtask

  task automatic do_halt(input int delay);
    send_byte(8'h03, 0);
    wait_tick(delay);
    m_nbr = 8'd0;
    check_state("after_halt");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    // Reset held 3 cycles, in_ready rises one cycle after release.
    reset = 1'b1;
    repeat (3) tick_cycle();
    check_reset_vals();
    reset = 1'b0;
    check("in_ready_before_first_edge", in_ready, 0);
    tick_cycle();
    check("in_ready_after_release", in_ready, 1);

    wq.push_back(32'h12345678);
    do_write(8'h05, 0, 1'b0);

    do_write(8'hFF, 1, 1'b0);

    do_commit(8'h07, 20);
    do_halt(3);
    do_commit(8'hFF, 0);
    do_commit(8'hFE, 1);

    send_byte(8'h9A, 0);
    m_err = 1'b1;
    check_state("after_bad_cmd");
    do_write(8'h20, 2, 1'b0);

    // Reset partway through a data word: no strobe, everything back to reset values.
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    repeat (2) tick_cycle();
    m_nbr = 8'd0;
    m_lb  = 8'd0;
    m_err = 1'b0;
    check_reset_vals();
    reset = 1'b0;
    tick_cycle();
    do_write(8'h10, 0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    do_commit(8'h03, 2);
    do_write(8'h40, 1, 1'b0);
    do_write(8'h50, 0, 1'b1);
`endif

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        do_write(8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
`else
        do_write(8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'b0);
`endif
      end else if (r <= 6) begin
        do_commit(8'($urandom_range(0, 255)), $urandom_range(0, 4));
      end else if (r == 7) begin
        do_halt($urandom_range(0, 4));
      end else begin
        send_byte(8'($urandom_range(4, 255)), 0);
        m_err = 1'b1;
        check_state("after_rand_bad_cmd");
      end
    end

    repeat (5) tick_cycle();
    check("scoreboard_drained", exp_q.size(), 0);
    check("strobe_count", strobes, exp_strobes);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
